// File: rtl/pulse_pacer.sv
// Paces bursty event strobes into single-cycle pulses spaced MIN_GAP clock_a cycles apart.
// Define PULSE_PACER_COALESCE_EN to merge the backlog into a single pending flag.
module pulse_pacer #(
    parameter int CNT_W   = 4,
    parameter int MIN_GAP = 4
) (
    input  logic             clock_a,
    input  logic             async_rst_n,
    input  logic             event_in,
    input  logic             clear,
    output logic             pls_out,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic             busy,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_PULSE = 3'b010,
        S_GAP   = 3'b100
    } state_e;

    localparam int               GAP_W    = 8;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e             state_q, state_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [CNT_W-1:0]   pending_q, pending_d;
    logic               overflow_q, overflow_d;

    logic               in_idle;
    logic               in_gap;
    logic               has_pend;
    logic               gap_done;
    logic               start;

    // A clear in the same cycle as a would-be launch suppresses that launch.
    always_comb begin
        in_idle  = (state_q == S_IDLE);
        in_gap   = (state_q == S_GAP);
        has_pend = (pending_q != '0);
        gap_done = (gap_q == '0);
        start    = !clear && has_pend && (in_idle || (in_gap && gap_done));
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PULSE;
                end
            end
            S_PULSE: begin
                state_d = S_GAP;
                gap_d   = GAP_LOAD;
            end
            S_GAP: begin
                if (gap_done) begin
                    state_d = start ? S_PULSE : S_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                gap_d   = '0;
            end
        endcase
    end

`ifdef PULSE_PACER_COALESCE_EN
    logic evt_ok;

    // Bit 0 alone tracks "something pending"; a new event re-arms it even on a launch cycle.
    always_comb begin
        evt_ok       = event_in && !clear;
        pending_d    = '0;
        pending_d[0] = !clear && (evt_ok || (pending_q[0] && !start));
        overflow_d   = 1'b0;
    end
`else
    logic evt_ok;
    logic full;
    logic inc;

    // When full, an event is only accepted if a launch frees a slot on the same edge.
    always_comb begin
        evt_ok     = event_in && !clear;
        full       = (pending_q == CNT_MAX);
        inc        = evt_ok && (!full || start);
        pending_d  = pending_q;
        if (clear) begin
            pending_d = '0;
        end else if (inc && !start) begin
            pending_d = pending_q + CNT_W'(1);
        end else if (!inc && start) begin
            pending_d = pending_q - CNT_W'(1);
        end
        overflow_d = clear ? 1'b0 : (overflow_q || (evt_ok && full && !start));
    end
`endif

    always_ff @(posedge clock_a or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q    <= S_IDLE;
            gap_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign pls_out   = state_q[1];
    assign pending   = pending_q;
    assign overflow  = overflow_q;
    assign busy      = !state_q[0] || (pending_q != '0);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pulse_pacer.sv
// Directed bench for pulse_pacer (CNT_W=4, MIN_GAP=4); expectations are hand-derived per cycle.
module tb_pulse_pacer;

    localparam int CNT_W   = 4;
    localparam int MIN_GAP = 4;

    localparam int ST_IDLE  = 1;
    localparam int ST_PULSE = 2;
    localparam int ST_GAP   = 4;

    logic             clock_a     = 1'b0;
    logic             async_rst_n = 1'b0;
    logic             event_in    = 1'b0;
    logic             clear       = 1'b0;
    logic             pls_out;
    logic [CNT_W-1:0] pending;
    logic             overflow;
    logic             busy;
    logic [2:0]       state_dbg;

    int n_cmp = 0;
    int n_err = 0;

`ifdef PULSE_PACER_COALESCE_EN
    int burst_pend[24] = '{0,1,1,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
`else
    int burst_pend[24] = '{0,1,1,2,3,4,3,3,3,3,2,2,2,2,1,1,1,1,0,0,0,0,0,0};
`endif
    int clr_pend[12]   = '{0,1,1,2,3,0,0,0,0,0,0,0};
    int clr2_pend[12]  = '{0,1,1,2,3,3,0,0,0,0,0,0};

    always #5 clock_a = ~clock_a;

    pulse_pacer #(.CNT_W(CNT_W), .MIN_GAP(MIN_GAP)) dut (
        .clock_a     (clock_a),
        .async_rst_n (async_rst_n),
        .event_in    (event_in),
        .clear       (clear),
        .pls_out     (pls_out),
        .pending     (pending),
        .overflow    (overflow),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, c, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock_a);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            next_cycle();
            n++;
        end
        chk("idle_timeout", n, 32'(busy), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int pulses;

        // Reset held with event_in toggling: all outputs stay at reset values.
        for (int i = 0; i < 6; i++) begin
            event_in = i[0];
            @(negedge clock_a);
            chk("rst_pls",   i, 32'(pls_out),   0);
            chk("rst_pend",  i, 32'(pending),   0);
            chk("rst_ovf",   i, 32'(overflow),  0);
            chk("rst_busy",  i, 32'(busy),      0);
            chk("rst_state", i, 32'(state_dbg), ST_IDLE);
        end
        next_cycle();
        event_in    = 1'b0;
        async_rst_n = 1'b1;

        // Single event at cycle 10.
        for (int c = 0; c < 20; c++) begin
            event_in = (c == 10);
            @(negedge clock_a);
            chk("single_pend",  c, 32'(pending),  (c == 11) ? 1 : 0);
            chk("single_pls",   c, 32'(pls_out),  int'(c == 12));
            chk("single_busy",  c, 32'(busy),     int'(c >= 11 && c <= 15));
            chk("single_ovf",   c, 32'(overflow), 0);
            chk("single_state", c, 32'(state_dbg),
                (c == 12) ? ST_PULSE : ((c >= 13 && c <= 15) ? ST_GAP : ST_IDLE));
            next_cycle();
        end
        event_in = 1'b0;
        wait_idle(40);

        // Burst of events at cycles 0-4.
        for (int c = 0; c < 24; c++) begin
            event_in = (c <= 4);
            @(negedge clock_a);
            chk("burst_pend", c, 32'(pending),  burst_pend[c]);
            chk("burst_ovf",  c, 32'(overflow), 0);
`ifdef PULSE_PACER_COALESCE_EN
            chk("burst_pls",  c, 32'(pls_out),  int'(c == 2 || c == 6));
            chk("burst_busy", c, 32'(busy),     int'(c >= 1 && c <= 9));
`else
            chk("burst_pls",  c, 32'(pls_out),  int'(c >= 2 && c <= 18 && ((c - 2) % 4) == 0));
            chk("burst_busy", c, 32'(busy),     int'(c >= 1 && c <= 21));
`endif
            next_cycle();
        end
        event_in = 1'b0;
        wait_idle(40);

        // Reset asserted mid-pulse truncates everything immediately.
        for (int c = 0; c < 2; c++) begin
            event_in = 1'b1;
            next_cycle();
        end
        event_in = 1'b0;
        @(negedge clock_a);
        chk("midrst_pls_before",  2, 32'(pls_out), 1);
        chk("midrst_pend_before", 2, 32'(pending), 1);
        #2;
        async_rst_n = 1'b0;
        #1;
        chk("midrst_pls",   2, 32'(pls_out),   0);
        chk("midrst_pend",  2, 32'(pending),   0);
        chk("midrst_busy",  2, 32'(busy),      0);
        chk("midrst_state", 2, 32'(state_dbg), ST_IDLE);
        next_cycle();
        async_rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock_a);
            chk("postrst_pls",  c, 32'(pls_out), 0);
            chk("postrst_busy", c, 32'(busy),    0);
            next_cycle();
        end

`ifndef PULSE_PACER_COALESCE_EN
        // Events at cycles 0-23: saturation at 15, three drops, 21 pulses.
        pulses = 0;
        for (int c = 0; c < 90; c++) begin
            event_in = (c <= 23);
            @(negedge clock_a);
            if (pls_out === 1'b1) pulses++;
            chk("ovf_pls",  c, 32'(pls_out),  int'(c >= 2 && c <= 82 && ((c - 2) % 4) == 0));
            chk("ovf_flag", c, 32'(overflow), int'(c >= 21));
            if (c == 20 || c == 22 || c == 24) chk("ovf_pend_full", c, 32'(pending), 15);
            next_cycle();
        end
        event_in = 1'b0;
        chk("ovf_pulse_count", 90, 32'(pulses), 21);
        chk("ovf_end_busy",    90, 32'(busy),   0);
        chk("ovf_end_pend",    90, 32'(pending), 0);

        // Clear during GAP with pending=3, coincident event is lost.
        for (int c = 0; c < 12; c++) begin
            event_in = (c <= 4);
            clear    = (c == 4);
            @(negedge clock_a);
            chk("clr_pend",  c, 32'(pending),  clr_pend[c]);
            chk("clr_ovf",   c, 32'(overflow), int'(c <= 4));
            chk("clr_pls",   c, 32'(pls_out),  int'(c == 2));
            chk("clr_busy",  c, 32'(busy),     int'(c >= 1 && c <= 5));
            next_cycle();
        end
        event_in = 1'b0;
        clear    = 1'b0;

        // Clear on the last GAP cycle, where a launch would otherwise start.
        for (int c = 0; c < 12; c++) begin
            event_in = (c <= 3);
            clear    = (c == 5);
            @(negedge clock_a);
            chk("clr2_pend",  c, 32'(pending),   clr2_pend[c]);
            chk("clr2_pls",   c, 32'(pls_out),   int'(c == 2));
            chk("clr2_busy",  c, 32'(busy),      int'(c >= 1 && c <= 5));
            chk("clr2_state", c, 32'(state_dbg),
                (c == 2) ? ST_PULSE : ((c >= 3 && c <= 5) ? ST_GAP : ST_IDLE));
            next_cycle();
        end
        event_in = 1'b0;
        clear    = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
